logic_unit_pipe: RTL and testbench

//   Parametrised, pipelined bitwise logic unit for the datapath ALU. Accepts (A, B, op, tag)
//   on a valid/ready handshake and evaluates one of 8 bitwise ops in stage 1. It produces

---
 rtl/logic_unit_pkg.sv | 38 +++
 rtl/logic_unit_stage.sv | 29 ++
 rtl/logic_unit_pipe.sv | 67 ++++++
 tb/tb_logic_unit_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared op encoding and the bitwise evaluation function for the pipelined logic unit.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_ANDN,
    OP_ORN,
    OP_XNOR,
    OP_PASSA
  } logic_op_e;

  // Widest operand the evaluator handles; callers zero-extend and truncate to their own width.
  localparam int unsigned LU_MAX_W = 64;

  function automatic logic [LU_MAX_W-1:0] logic_eval(
    logic_op_e             op,
    logic [LU_MAX_W-1:0]   a,
    logic [LU_MAX_W-1:0]   b
  );
    logic [LU_MAX_W-1:0] r;
    r = a;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOR:   r = ~(a | b);
      OP_ANDN:  r = a & ~b;
      OP_ORN:   r = a | ~b;
      OP_XNOR:  r = ~(a ^ b);
      OP_PASSA: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// One valid/ready register slice; loads whenever it is empty or its consumer is taking data.
module logic_unit_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: op evaluated into stage 1, flags ride with the result,
// later stages are pure transport under a valid/ready chain.
module logic_unit_pipe #(
  parameter int unsigned N           = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_par,
  output logic             out_ones
);

  import logic_unit_pkg::*;

  localparam int unsigned W = TAG_W + 3 + N;

  logic [N-1:0] r1;
  logic         zero1;
  logic         par1;
  logic         ones1;

  assign r1    = N'(logic_eval(logic_op_e'(in_op), LU_MAX_W'(in_a), LU_MAX_W'(in_b)));
  assign zero1 = (r1 == '0);
  assign par1  = ^r1;
  assign ones1 = &r1;

  // Index 0 is the input side, index PIPE_STAGES the output side of the slice chain.
  logic [PIPE_STAGES:0]        v;
  logic [PIPE_STAGES:0]        rdy;
  logic [PIPE_STAGES:0][W-1:0] d;

  assign v[0]           = in_valid;
  assign d[0]           = {in_tag, ones1, par1, zero1, r1};
  assign rdy[PIPE_STAGES] = out_ready;

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    logic_unit_stage #(
      .W(W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v[i]),
      .in_data   (d[i]),
      .in_ready  (rdy[i]),
      .out_valid (v[i+1]),
      .out_data  (d[i+1]),
      .out_ready (rdy[i+1])
    );
  end

  assign in_ready  = rdy[0] & rst_n;
  assign out_valid = v[PIPE_STAGES];
  assign {out_tag, out_ones, out_par, out_zero, out_r} = d[PIPE_STAGES];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: three configurations share stimulus, each with its own scoreboard.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;

  logic        m_in_ready, m_out_valid, m_zero, m_par, m_ones;
  logic [31:0] m_out_r;
  logic [3:0]  m_out_tag;
  logic        a_in_ready, a_out_valid, a_zero, a_par, a_ones;
  logic [0:0]  a_out_r;
  logic [3:0]  a_out_tag;
  logic        b_in_ready, b_out_valid, b_zero, b_par, b_ones;
  logic [31:0] b_out_r;
  logic [3:0]  b_out_tag;

  logic_unit_pipe #(.N(32), .PIPE_STAGES(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_r(m_out_r), .out_tag(m_out_tag),
    .out_zero(m_zero), .out_par(m_par), .out_ones(m_ones)
  );

  logic_unit_pipe #(.N(1), .PIPE_STAGES(4), .TAG_W(4)) u_dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_a(in_a[0:0]), .in_b(in_b[0:0]), .in_op(in_op), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_r(a_out_r), .out_tag(a_out_tag),
    .out_zero(a_zero), .out_par(a_par), .out_ones(a_ones)
  );

  logic_unit_pipe #(.N(32), .PIPE_STAGES(1), .TAG_W(4)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_r(b_out_r), .out_tag(b_out_tag),
    .out_zero(b_zero), .out_par(b_par), .out_ones(b_ones)
  );

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  tag;
  } exp_t;

  exp_t qm[$];
  exp_t qa[$];
  exp_t qb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [31:0] ref32(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    return 32'(logic_eval(logic_op_e'(op), 64'(a), 64'(b)));
  endfunction

  // Pushes on input accept, pops and compares on output accept, for all three DUTs.
  task automatic scoreboard();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qm.delete();
        qa.delete();
        qb.delete();
      end else begin
        if (m_out_valid && out_ready) begin
          vectors++;
          if (qm.size() == 0) begin
            miscompares++;
            $display("FAIL sb_main: unexpected result r=%h tag=%h, expected nothing outstanding", m_out_r, m_out_tag);
          end else begin
            e = qm.pop_front();
            if (m_out_r !== e.r || m_out_tag !== e.tag || m_zero !== (e.r == 32'h0) ||
                m_par !== ^e.r || m_ones !== &e.r) begin
              miscompares++;
              $display("FAIL sb_main: got r=%h tag=%h zpo=%b%b%b, expected r=%h tag=%h zpo=%b%b%b",
                       m_out_r, m_out_tag, m_zero, m_par, m_ones,
                       e.r, e.tag, (e.r == 32'h0), ^e.r, &e.r);
            end
          end
        end
        if (a_out_valid && out_ready) begin
          vectors++;
          if (qa.size() == 0) begin
            miscompares++;
            $display("FAIL sb_n1: unexpected result r=%b tag=%h, expected nothing outstanding", a_out_r, a_out_tag);
          end else begin
            e = qa.pop_front();
            if (a_out_r !== e.r[0:0] || a_out_tag !== e.tag || a_zero !== ~e.r[0] ||
                a_par !== e.r[0] || a_ones !== e.r[0]) begin
              miscompares++;
              $display("FAIL sb_n1: got r=%b tag=%h zpo=%b%b%b, expected r=%b tag=%h zpo=%b%b%b",
                       a_out_r, a_out_tag, a_zero, a_par, a_ones,
                       e.r[0], e.tag, ~e.r[0], e.r[0], e.r[0]);
            end
          end
        end
        if (b_out_valid && out_ready) begin
          vectors++;
          if (qb.size() == 0) begin
            miscompares++;
            $display("FAIL sb_p1: unexpected result r=%h tag=%h, expected nothing outstanding", b_out_r, b_out_tag);
          end else begin
            e = qb.pop_front();
            if (b_out_r !== e.r || b_out_tag !== e.tag || b_zero !== (e.r == 32'h0) ||
                b_par !== ^e.r || b_ones !== &e.r) begin
              miscompares++;
              $display("FAIL sb_p1: got r=%h tag=%h zpo=%b%b%b, expected r=%h tag=%h zpo=%b%b%b",
                       b_out_r, b_out_tag, b_zero, b_par, b_ones,
                       e.r, e.tag, (e.r == 32'h0), ^e.r, &e.r);
            end
          end
        end
        e.r   = ref32(in_op, in_a, in_b);
        e.tag = in_tag;
        if (in_valid && m_in_ready) qm.push_back(e);
        if (in_valid && b_in_ready) qb.push_back(e);
        e.r = {31'b0, e.r[0]};
        if (in_valid && a_in_ready) qa.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({m_in_ready, m_out_valid, m_out_r, m_out_tag, m_zero, m_par, m_ones} !== 41'b0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b vld=%b r=%h tag=%h zpo=%b%b%b, expected all 0",
               m_in_ready, m_out_valid, m_out_r, m_out_tag, m_zero, m_par, m_ones);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_op = 3'($urandom_range(7));
      in_tag = 4'(i + 1);
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midstream: got out_valid=%b in_ready=%b, expected 0 0", m_out_valid, m_in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (m_out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stale: cycle %0d got out_valid=%b r=%h, expected 0", i, m_out_valid, m_out_r);
      end
    end
  endtask

  task automatic test_ops();
    logic [31:0] exp_r [8] = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h000F_0000,
                               32'hF000_0000, 32'hF0FF_1234, 32'h00FF_1234, 32'hF0F0_1234};
    out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 32'hF0F0_1234; in_b = 32'h0FF0_FFFF;
      in_op = 3'(op); in_tag = 4'(op + 3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (m_out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL op%0d_early: got out_valid=%b one edge after accept, expected 0", op, m_out_valid);
      end
      @(negedge clk);
      vectors++;
      if (m_out_valid !== 1'b1 || m_out_r !== exp_r[op] || m_out_tag !== 4'(op + 3)) begin
        miscompares++;
        $display("FAIL op%0d_result: got vld=%b r=%h tag=%h, expected vld=1 r=%h tag=%h",
                 op, m_out_valid, m_out_r, m_out_tag, exp_r[op], 4'(op + 3));
      end
    end
  endtask

  task automatic test_flags();
    logic [31:0] fa [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_FFFF};
    logic [31:0] fb [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_0000};
    logic [2:0]  fo [3] = '{3'b000, 3'b010, 3'b000};
    logic [2:0]  fz [3] = '{3'b001, 3'b010, 3'b100};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = fa[i]; in_b = fb[i]; in_op = fo[i]; in_tag = 4'(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (m_out_valid !== 1'b1 || {m_zero, m_par, m_ones} !== fz[i]) begin
        miscompares++;
        $display("FAIL flags%0d: got vld=%b zpo=%b%b%b, expected vld=1 zpo=%b",
                 i, m_out_valid, m_zero, m_par, m_ones, fz[i]);
      end
    end
  endtask

  task automatic test_stream();
    int         got = 0;
    int         first = -1;
    int         last = -1;
    logic [3:0] exp_tag = 4'd0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 110; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 100) begin
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_op = 3'($urandom_range(7));
        in_tag = cyc[3:0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc < 100 && m_in_ready !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL stream_ready: cycle %0d got in_ready=%b, expected 1", cyc, m_in_ready);
      end
      if (m_out_valid === 1'b1) begin
        vectors++;
        if (m_out_tag !== exp_tag) begin
          miscompares++;
          $display("FAIL stream_tag: got tag=%h, expected %h", m_out_tag, exp_tag);
        end
        exp_tag++;
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    vectors++;
    if (got != 100 || last - first != 99) begin
      miscompares++;
      $display("FAIL stream_count: got %0d results over %0d cycles, expected 100 over 100", got, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    int          acc = 0;
    logic        held_v = 1'b0;
    logic [31:0] held_r = '0;
    logic [3:0]  held_t = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_op = 3'($urandom_range(7));
      in_tag = 4'(i + 8);
      @(negedge clk);
      if (m_in_ready === 1'b1) acc++;
      if (m_out_valid === 1'b1) begin
        if (!held_v) begin
          held_v = 1'b1; held_r = m_out_r; held_t = m_out_tag;
        end else begin
          vectors++;
          if (m_out_r !== held_r || m_out_tag !== held_t) begin
            miscompares++;
            $display("FAIL bp_stable: got r=%h tag=%h, expected held r=%h tag=%h", m_out_r, m_out_tag, held_r, held_t);
          end
        end
      end
    end
    vectors++;
    if (acc != 2 || m_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accepts: got %0d accepts, in_ready=%b, expected 2 accepts, in_ready=0", acc, m_in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    vectors++;
    if (qm.size() != 0) begin
      miscompares++;
      $display("FAIL bp_drain: got %0d results outstanding, expected 0", qm.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_a = $urandom; in_b = $urandom; in_op = 3'($urandom_range(7)); in_tag = 4'($urandom_range(15));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (qm.size() != 0 || qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: got outstanding main=%0d n1=%0d p1=%0d, expected 0 0 0",
               qm.size(), qa.size(), qb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    fork
      scoreboard();
    join_none
    test_reset();
    test_ops();
    test_flags();
    test_stream();
    test_backpressure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
